pd_rx_framer: RTL and testbench

- USB-PD receive framer and controller for the BMC decoder.
- Enables the decoder and consumes its per-bit strobe (rdy, bit, packet-start).
- Hunts for the SOP ordered set, classifies it, 4b5b-decodes the payload into bytes, detects EOP and checks the CRC-32.
- Sits between the BMC decoder and the PD protocol layer.

---
 rtl/pd_rx_pkg.sv | 88 ++++++++
 rtl/pd_crc32.sv | 40 ++++
 rtl/pd_rx_framer.sv | 247 ++++++++++++++++++++++++
 tb/tb_pd_rx_framer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_rx_pkg.sv
// Shared definitions for the USB-PD receive framer: 5b line codes, ordered-set
// patterns, encodings, FSM states, CRC-32 constants and the 4b5b decoder.
package pd_rx_pkg;

  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_SYNC3 = 5'b00110;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_RST2  = 5'b11001;
  localparam logic [4:0] K_EOP   = 5'b01101;

  typedef enum logic [2:0] {
    SOP_T         = 3'd0,
    SOP_P_T       = 3'd1,
    SOP_PP_T      = 3'd2,
    HARD_RESET_T  = 3'd3,
    CABLE_RESET_T = 3'd4
  } sop_type_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SYMBOL   = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_ABORT    = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    WAIT = 2'd3
  } state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int NUM_OS = 5;

  // Returns {valid, is_k, nibble}; K-codes report valid with a zero nibble.
  function automatic logic [5:0] dec4b5b(input logic [4:0] code);
    logic [5:0] res;
    case (code)
      5'b11110: res = {2'b10, 4'h0};
      5'b01001: res = {2'b10, 4'h1};
      5'b10100: res = {2'b10, 4'h2};
      5'b10101: res = {2'b10, 4'h3};
      5'b01010: res = {2'b10, 4'h4};
      5'b01011: res = {2'b10, 4'h5};
      5'b01110: res = {2'b10, 4'h6};
      5'b01111: res = {2'b10, 4'h7};
      5'b10010: res = {2'b10, 4'h8};
      5'b10011: res = {2'b10, 4'h9};
      5'b10110: res = {2'b10, 4'hA};
      5'b10111: res = {2'b10, 4'hB};
      5'b11010: res = {2'b10, 4'hC};
      5'b11011: res = {2'b10, 4'hD};
      5'b11100: res = {2'b10, 4'hE};
      5'b11101: res = {2'b10, 4'hF};
      K_SYNC1, K_SYNC2, K_SYNC3, K_RST1, K_RST2, K_EOP: res = {2'b11, 4'h0};
      default: res = 6'b000000;
    endcase
    return res;
  endfunction

  // Window layout: oldest K-code in bits [4:0], newest in [19:15].
  function automatic logic [19:0] os_pattern(input int idx);
    logic [19:0] pat;
    case (idx)
      0:       pat = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
      1:       pat = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
      2:       pat = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
      3:       pat = {K_RST2,  K_RST1,  K_RST1,  K_RST1};
      default: pat = {K_SYNC3, K_RST1,  K_SYNC1, K_RST1};
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] os_match_count(input logic [19:0] win, input logic [19:0] pat);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (win[5*k +: 5] == pat[5*k +: 5]) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pd_crc32.sv
// Byte-wide reflected CRC-32 register (LSB-first) with synchronous clear-to-init
// and load-byte controls.
module pd_crc32
  import pd_rx_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;
  logic [31:0] step;

  always_comb begin
    step = crc_q ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      step = step[0] ? ((step >> 1) ^ CRC_POLY) : (step >> 1);
    end
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (load) begin
      crc_d = step;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      crc_q <= 32'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/pd_rx_framer.sv
// USB-PD receive framer: ordered-set hunt, 4b5b payload decode, EOP and CRC-32 check.
// Build option PD_SOP_TOLERANT_EN accepts ordered sets with 3 of 4 matching K-codes.
module pd_rx_framer
  import pd_rx_pkg::*;
#(
  parameter int MAX_BYTES = 34,
  parameter int HUNT_MAX  = 128
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_en,
  output logic       dec_en,
  input  logic       bit_rdy,
  input  logic       bit_in,
  input  logic       pkt_act,
  output logic       sop_valid,
  output logic [2:0] sop_type,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       crc_ok,
  output logic       rx_err,
  output logic [1:0] err_code
);

  localparam int HC_W = $clog2(HUNT_MAX + 1);
  localparam int BC_W = $clog2(MAX_BYTES + 1);
  localparam logic [HC_W-1:0] HUNT_LAST  = HC_W'(HUNT_MAX - 1);
  localparam logic [BC_W-1:0] BYTE_LIMIT = BC_W'(MAX_BYTES);
  localparam logic [BC_W-1:0] CRC_MIN    = BC_W'(4);

  state_e          state_q, state_d;
  logic [19:0]     sr_q, sr_d, sr_shift;
  logic [HC_W-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      nib_q, nib_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic            dec_en_q, dec_en_d;
  logic            sop_valid_q, sop_valid_d;
  logic [2:0]      sop_type_q, sop_type_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_done_q, rx_done_d;
  logic            crc_ok_q, crc_ok_d;
  logic            rx_err_q, rx_err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [NUM_OS-1:0] os_hit;
  logic              os_found;
  sop_type_e         os_type;
  logic [4:0]        sym;
  logic [5:0]        sym_dec;
  logic              sym_valid, sym_k;
  logic [3:0]        sym_nib;
  logic              crc_clr, crc_load;
  logic [7:0]        crc_byte;
  logic [31:0]       crc_val;

  // The window is judged including the bit arriving this cycle.
  assign sr_shift  = {bit_in, sr_q[19:1]};
  assign sym       = sr_shift[19:15];
  assign sym_dec   = dec4b5b(sym);
  assign sym_valid = sym_dec[5];
  assign sym_k     = sym_dec[4];
  assign sym_nib   = sym_dec[3:0];
  assign crc_byte  = {sym_nib, nib_q};

  generate
    for (genvar gi = 0; gi < NUM_OS; gi++) begin : g_os
      logic [2:0] hits;
      assign hits = os_match_count(sr_shift, os_pattern(gi));
`ifdef PD_SOP_TOLERANT_EN
      assign os_hit[gi] = (hits >= 3'd3);
`else
      assign os_hit[gi] = (hits == 3'd4);
`endif
    end
  endgenerate

  // Reset ordered sets outrank SOP types, then the lowest type wins.
  always_comb begin
    os_found = |os_hit;
    if (os_hit[3])      os_type = HARD_RESET_T;
    else if (os_hit[4]) os_type = CABLE_RESET_T;
    else if (os_hit[0]) os_type = SOP_T;
    else if (os_hit[1]) os_type = SOP_P_T;
    else                os_type = SOP_PP_T;
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = bit_rdy ? sr_shift : sr_q;
    hunt_cnt_d  = hunt_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    nib_d       = nib_q;
    byte_cnt_d  = byte_cnt_q;
    dec_en_d    = rx_en;
    sop_valid_d = 1'b0;
    sop_type_d  = sop_type_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_done_d   = 1'b0;
    crc_ok_d    = crc_ok_q;
    rx_err_d    = 1'b0;
    err_code_d  = err_code_q;
    crc_clr     = 1'b0;
    crc_load    = 1'b0;

    if (!rx_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pkt_act) begin
            state_d    = HUNT;
            hunt_cnt_d = '0;
            sr_d       = '0;
          end
        end
        HUNT: begin
          if (bit_rdy) begin
            if (os_found) begin
              sop_valid_d = 1'b1;
              sop_type_d  = os_type;
              crc_ok_d    = 1'b0;
              if (os_type == HARD_RESET_T || os_type == CABLE_RESET_T) begin
                state_d = WAIT;
              end else begin
                state_d    = DATA;
                crc_clr    = 1'b1;
                byte_cnt_d = '0;
                bit_cnt_d  = 4'd0;
              end
            end else if (hunt_cnt_q == HUNT_LAST) begin
              rx_err_d   = 1'b1;
              err_code_d = ERR_ABORT;
              state_d    = WAIT;
            end else begin
              hunt_cnt_d = hunt_cnt_q + HC_W'(1);
            end
          end else if (!pkt_act) begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (bit_rdy) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd4) begin
              if (sym == K_EOP) begin
                rx_done_d = 1'b1;
                crc_ok_d  = (crc_val == CRC_RESIDUE) && (byte_cnt_q >= CRC_MIN);
                state_d   = WAIT;
              end else if (!sym_valid || sym_k) begin
                rx_err_d   = 1'b1;
                err_code_d = ERR_SYMBOL;
                state_d    = WAIT;
              end else begin
                nib_d = sym_nib;
              end
            end else if (bit_cnt_q == 4'd9) begin
              bit_cnt_d = 4'd0;
              if (!sym_valid || sym_k) begin
                rx_err_d   = 1'b1;
                err_code_d = ERR_SYMBOL;
                state_d    = WAIT;
              end else if (byte_cnt_q == BYTE_LIMIT) begin
                rx_err_d   = 1'b1;
                err_code_d = ERR_OVERFLOW;
                state_d    = WAIT;
              end else begin
                rx_valid_d = 1'b1;
                rx_data_d  = crc_byte;
                crc_load   = 1'b1;
                byte_cnt_d = byte_cnt_q + BC_W'(1);
              end
            end
          end else if (!pkt_act) begin
            // A strobe coinciding with activity loss was handled above; abort now.
            rx_err_d   = 1'b1;
            err_code_d = ERR_ABORT;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (!pkt_act) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hunt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      nib_q       <= '0;
      byte_cnt_q  <= '0;
      dec_en_q    <= 1'b0;
      sop_valid_q <= 1'b0;
      sop_type_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      crc_ok_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hunt_cnt_q  <= hunt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      nib_q       <= nib_d;
      byte_cnt_q  <= byte_cnt_d;
      dec_en_q    <= dec_en_d;
      sop_valid_q <= sop_valid_d;
      sop_type_q  <= sop_type_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_done_q   <= rx_done_d;
      crc_ok_q    <= crc_ok_d;
      rx_err_q    <= rx_err_d;
      err_code_q  <= err_code_d;
    end
  end

  pd_crc32 u_crc (
    .clock (clock),
    .rst   (rst),
    .clr   (crc_clr),
    .load  (crc_load),
    .data  (crc_byte),
    .crc   (crc_val)
  );

  assign dec_en    = dec_en_q;
  assign sop_valid = sop_valid_q;
  assign sop_type  = sop_type_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_done   = rx_done_q;
  assign crc_ok    = crc_ok_q;
  assign rx_err    = rx_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_pd_rx_framer.sv
// Self-checking bench for pd_rx_framer: frame vector table plus corner-case sequences,
// with DUT output pulses checked against an expected-event queue.
module tb_pd_rx_framer;

  localparam logic [4:0] S1  = 5'b11000;
  localparam logic [4:0] S2  = 5'b10001;
  localparam logic [4:0] S3  = 5'b00110;
  localparam logic [4:0] R1  = 5'b00111;
  localparam logic [4:0] R2  = 5'b11001;
  localparam logic [4:0] EOP = 5'b01101;

  localparam int EV_SOP  = 0;
  localparam int EV_BYTE = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  logic       clock = 1'b0;
  logic       rst, rx_en, bit_rdy, bit_in, pkt_act;
  logic       dec_en, sop_valid, rx_valid, rx_done, crc_ok, rx_err;
  logic [2:0] sop_type;
  logic [7:0] rx_data;
  logic [1:0] err_code;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    int         len;
    logic [7:0] pay[4];
    bit         add_crc;
    int         flip;
    bit         exp_ok;
  } frame_vec_t;
  frame_vec_t vecs[5];

  always #5 clock = ~clock;

  pd_rx_framer dut (
    .clock     (clock),
    .rst       (rst),
    .rx_en     (rx_en),
    .dec_en    (dec_en),
    .bit_rdy   (bit_rdy),
    .bit_in    (bit_in),
    .pkt_act   (pkt_act),
    .sop_valid (sop_valid),
    .sop_type  (sop_type),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_done   (rx_done),
    .crc_ok    (crc_ok),
    .rx_err    (rx_err),
    .err_code  (err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] val);
    ev_t e;
    $display("t=%0t event kind=%0d value=%0h", $time, kind, val);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d value %0h, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk("event", {16'd0, kind[7:0], val}, {16'd0, e.kind[7:0], e.val});
    end
  endtask

  always @(negedge clock) begin
    if (sop_valid) check_ev(EV_SOP, {5'd0, sop_type});
    if (rx_valid)  check_ev(EV_BYTE, rx_data);
    if (rx_done)   check_ev(EV_DONE, {7'd0, crc_ok});
    if (rx_err)    check_ev(EV_ERR, {6'd0, err_code});
  end

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 5'b11110;  4'h1: enc = 5'b01001;  4'h2: enc = 5'b10100;  4'h3: enc = 5'b10101;
      4'h4: enc = 5'b01010;  4'h5: enc = 5'b01011;  4'h6: enc = 5'b01110;  4'h7: enc = 5'b01111;
      4'h8: enc = 5'b10010;  4'h9: enc = 5'b10011;  4'hA: enc = 5'b10110;  4'hB: enc = 5'b10111;
      4'hC: enc = 5'b11010;  4'hD: enc = 5'b11011;  4'hE: enc = 5'b11100;  default: enc = 5'b11101;
    endcase
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_rdy = 1'b1;
    @(posedge clock); #1;
    bit_rdy = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic send_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) send_bit(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_sym(enc(b[3:0]));
    send_sym(enc(b[7:4]));
  endtask

  task automatic send_os(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    send_sym(a); send_sym(b); send_sym(c); send_sym(d);
  endtask

  task automatic send_alt(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0]);
  endtask

  task automatic begin_frame();
    pkt_act = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    send_alt(64);
  endtask

  task automatic end_frame(input string tag);
    repeat (3) @(posedge clock);
    #1;
    pkt_act = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk({"drain_", tag}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_vec(input int idx, input int len, input logic [31:0] bytes,
                         input bit add_crc, input int flip, input bit ok);
    vecs[idx].len     = len;
    for (int k = 0; k < 4; k++) vecs[idx].pay[k] = bytes[8*k +: 8];
    vecs[idx].add_crc = add_crc;
    vecs[idx].flip    = flip;
    vecs[idx].exp_ok  = ok;
  endtask

  task automatic run_frame(input int idx);
    logic [7:0]  fq[$];
    logic [31:0] c;
    fq = {};
    for (int i = 0; i < vecs[idx].len; i++) fq.push_back(vecs[idx].pay[i]);
    if (vecs[idx].add_crc) begin
      c = 32'hFFFFFFFF;
      foreach (fq[i]) c = crc_upd(c, fq[i]);
      c = ~c;
      if (vecs[idx].flip >= 0) c[vecs[idx].flip] = ~c[vecs[idx].flip];
      for (int k = 0; k < 4; k++) fq.push_back(c[8*k +: 8]);
    end
    push_ev(EV_SOP, 8'd0);
    foreach (fq[i]) push_ev(EV_BYTE, fq[i]);
    push_ev(EV_DONE, {7'd0, vecs[idx].exp_ok});
    begin_frame();
    send_os(S1, S1, S1, S2);
    foreach (fq[i]) send_byte(fq[i]);
    send_sym(EOP);
    send_bit(1'b0);
    send_bit(1'b1);
    end_frame($sformatf("frame%0d", idx));
    chk("crc_ok_held", {31'd0, crc_ok}, {31'd0, vecs[idx].exp_ok});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_en = 1'b1; bit_rdy = 1'b0; bit_in = 1'b0; pkt_act = 1'b0;

    set_vec(0, 2, 32'h0000_0041, 1'b1, -1, 1'b1);
    set_vec(1, 2, 32'h0000_0041, 1'b1,  5, 1'b0);
    set_vec(2, 0, 32'h0000_0000, 1'b1, -1, 1'b1);
    set_vec(3, 3, 32'h0056_3412, 1'b0, -1, 1'b0);
    set_vec(4, 4, 32'hEFBE_ADDE, 1'b1, -1, 1'b1);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_dec_en",    {31'd0, dec_en},    0);
    chk("rst_sop_valid", {31'd0, sop_valid}, 0);
    chk("rst_sop_type",  {29'd0, sop_type},  0);
    chk("rst_rx_data",   {24'd0, rx_data},   0);
    chk("rst_rx_valid",  {31'd0, rx_valid},  0);
    chk("rst_rx_done",   {31'd0, rx_done},   0);
    chk("rst_crc_ok",    {31'd0, crc_ok},    0);
    chk("rst_rx_err",    {31'd0, rx_err},    0);
    chk("rst_err_code",  {30'd0, err_code},  0);
    rst = 1'b0;
    @(posedge clock); #1;
    chk("dec_en_follow", {31'd0, dec_en}, 1);

    for (int v = 0; v < 5; v++) run_frame(v);

    // Hard reset ordered set: type 3, tail ignored while waiting for activity loss.
    push_ev(EV_SOP, 8'd3);
    begin_frame();
    send_os(R1, R1, R1, R2);
    send_byte(8'h55);
    end_frame("hard_reset");
    chk("sop_type_held", {29'd0, sop_type}, 3);

    // Invalid data symbol as the first symbol of a byte.
    push_ev(EV_SOP, 8'd0);
    push_ev(EV_ERR, 8'd1);
    begin_frame();
    send_os(S1, S1, S1, S2);
    send_sym(5'b00000);
    send_byte(8'h12);
    end_frame("bad_symbol");
    chk("err_code_held", {30'd0, err_code}, 1);

    // 35 valid bytes with no EOP: 34 accepted, the 35th overflows.
    push_ev(EV_SOP, 8'd0);
    for (int i = 0; i < 34; i++) push_ev(EV_BYTE, 8'(i * 7 + 3));
    push_ev(EV_ERR, 8'd2);
    begin_frame();
    send_os(S1, S1, S1, S2);
    for (int i = 0; i < 35; i++) send_byte(8'(i * 7 + 3));
    end_frame("overflow");

    // Second Sync1 corrupted, followed by 140 alternating bits (0x34 bytes if in DATA).
`ifdef PD_SOP_TOLERANT_EN
    push_ev(EV_SOP, 8'd0);
    for (int i = 0; i < 14; i++) push_ev(EV_BYTE, 8'h34);
    push_ev(EV_ERR, 8'd3);
`else
    push_ev(EV_ERR, 8'd3);
`endif
    begin_frame();
    send_os(S1, 5'b11010, S1, S2);
    send_alt(140);
    end_frame("corrupt_sop");
    chk("err_code_abort", {30'd0, err_code}, 3);

    // rx_en dropped mid-DATA: frame discarded silently.
    push_ev(EV_SOP, 8'd0);
    push_ev(EV_BYTE, 8'h11);
    push_ev(EV_BYTE, 8'h22);
    begin_frame();
    send_os(S1, S1, S1, S2);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_en = 1'b0;
    chk("dec_en_before_drop", {31'd0, dec_en}, 1);
    @(posedge clock); #1;
    chk("dec_en_after_drop", {31'd0, dec_en}, 0);
    send_byte(8'h33);
    send_sym(EOP);
    pkt_act = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rx_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("dec_en_restored", {31'd0, dec_en}, 1);
    end_frame("rx_en_drop");

    run_frame(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
